keypad_scanner: RTL

Matrix-keypad front end for the parcel locker: drives the 4×4 keypad columns, samples the rows, debounces and decodes one key at a time, and hands the Operator a 4-bit key code with a one-cycle enable pulse. It sits between the keypad pins and the Operator. It replaces the per-row debounce instances and the ad-hoc scanner with one synchronous state machine, and it enforces a single report per physical press plus lockout while the Screen animation plays.

---
 rtl/locker_pkg.sv | 55 +++++
 rtl/keypad_scanner_sync.sv | 25 ++
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/locker_pkg.sv
// Shared locker definitions: key codes seen by the Operator and the scanner state encoding.
package locker_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } scan_state_e;

  // Decode ROM: keypad legend at row/column position.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_A;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_B;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Index of the single set bit in a one-hot nibble.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for asynchronous inputs, parametrizable width.
module sync2 #(
  parameter int unsigned W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row debounce, single report per press, playback lockout.
module keypad_scanner
  import locker_pkg::*;
#(
  parameter int unsigned DWELL      = 4,
  parameter int unsigned DEB_CYCLES = 10
) (
  input  logic       clk_1k,
  input  logic       rst,
  input  logic [3:0] kbrow,
  input  logic       playing,
  output logic [3:0] kbcol,
  output logic [3:0] num_in,
  output logic       kb_en,
  output logic       multi
);

  scan_state_e      state, state_d;
  logic [1:0]       col, col_d;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_d;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_d;
  logic [3:0]       pat, pat_d;
  logic [3:0]       code, code_d;
  logic [3:0]       kbcol_d, num_in_d;
  logic             kb_en_d, multi_d;

  logic [3:0]       rs;
  logic [3:0]       low;
  logic             any_low, single_low;

  sync2 #(.W(4), .RST_VAL(4'hF)) u_sync (
    .clk   (clk_1k),
    .rst_n (rst),
    .d     (kbrow),
    .q     (rs)
  );

  assign low        = ~rs;
  assign any_low    = |low;
  assign single_low = any_low && ((low & (low - 4'd1)) == 4'd0);

  // State and output registers.
  always_ff @(posedge clk_1k or negedge rst) begin
    if (!rst) begin
      state     <= ST_SCAN;
      col       <= 2'd0;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      pat       <= 4'hF;
      code      <= 4'h0;
      kbcol     <= 4'b1110;
      num_in    <= 4'h0;
      kb_en     <= 1'b0;
      multi     <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      dwell_cnt <= dwell_cnt_d;
      deb_cnt   <= deb_cnt_d;
      pat       <= pat_d;
      code      <= code_d;
      kbcol     <= kbcol_d;
      num_in    <= num_in_d;
      kb_en     <= kb_en_d;
      multi     <= multi_d;
    end
  end

  // Scan / debounce / release sequencing and registered output values.
  always_comb begin
    state_d     = state;
    col_d       = col;
    dwell_cnt_d = dwell_cnt;
    deb_cnt_d   = deb_cnt;
    pat_d       = pat;
    code_d      = code;
    num_in_d    = num_in;
    kb_en_d     = 1'b0;
    multi_d     = multi;

    case (state)
      ST_SCAN: begin
        if (dwell_cnt == CNT_W'(DWELL - 1)) begin
          dwell_cnt_d = '0;
          if (single_low) begin
            pat_d     = rs;
            code_d    = key_code(onehot_index(low), col);
            deb_cnt_d = '0;
            multi_d   = 1'b0;
            state_d   = ST_DEBOUNCE;
          end else if (!any_low) begin
            multi_d = 1'b0;
            col_d   = col + 2'd1;
          end else begin
            multi_d = 1'b1;
            col_d   = col + 2'd1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt + CNT_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (rs != pat) begin
          col_d       = col + 2'd1;
          dwell_cnt_d = '0;
          state_d     = ST_SCAN;
        end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          if (!playing) begin
            num_in_d = code;
            kb_en_d  = 1'b1;
          end
          deb_cnt_d = '0;
          state_d   = ST_RELEASE;
        end else begin
          deb_cnt_d = deb_cnt + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (rs == 4'hF) begin
          if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            deb_cnt_d   = '0;
            dwell_cnt_d = '0;
            col_d       = 2'd0;
            state_d     = ST_SCAN;
          end else begin
            deb_cnt_d = deb_cnt + CNT_W'(1);
          end
        end else begin
          deb_cnt_d = '0;
        end
      end

      default: begin
        state_d     = ST_SCAN;
        col_d       = 2'd0;
        dwell_cnt_d = '0;
        deb_cnt_d   = '0;
      end
    endcase

    kbcol_d = ~(4'(4'b0001 << col_d));
  end

endmodule
